score_unit: RTL and testbench

- Scoring and lives stage directly downstream of hit_detection.
- Consumes the per-pixel collision levels (player-missile-vs-monster, monster-missile-vs-player), debounces them to one event per frame and accumulates a BCD score.
- Tracks player lives and drives player_dead / win_stage into the game controller.
- Drives 7-segment patterns for the board HEX displays.

---
 rtl/score_pkg.sv | 25 ++
 rtl/bcd_to_7seg.sv | 13 +
 rtl/score_unit.sv | 172 +++++++++++++++++
 tb/tb_score_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and 7-segment constants for the score_unit slice.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ADD  = 1'b1
  } score_state_t;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [SEG_W-1:0] seg_of(input bcd_digit_t d);
    return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One-digit BCD to active-low 7-segment decoder; codes above 9 show blank.
module bcd_to_7seg
  import score_pkg::*;
(
  input  bcd_digit_t       digit,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = seg_of(digit);
  end

endmodule

// File: rtl/score_unit.sv
// Scoring and lives stage: per-frame hit debounce, BCD score adder, lives and
// 7-segment drive. Optional HIGH_SCORE_EN adds a high-score register/display.
//
// state | meaning
// IDLE  | no pending points
// ADD   | adding one point per cycle to score_bcd, pending draining
module score_unit
  import score_pkg::*;
#(
  parameter int DIGITS             = 4,
  parameter int HEX_WIDTH          = 7,
  parameter int KILL_POINTS        = 10,
  parameter int MONSTERS_PER_STAGE = 16,
  parameter int START_LIVES        = 3,
  parameter int INVULN_FRAMES      = 60
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        startOfFrame,
  input  logic                        enable,
  input  logic                        new_game,
  input  logic                        stage_clear,
  input  logic [2:0]                  stage_num,
  input  logic                        monster_hit,
  input  logic                        player_hit,
  output logic [4*DIGITS-1:0]         score_bcd,
  output logic [DIGITS*HEX_WIDTH-1:0] hex_segments,
  output logic [2:0]                  lives,
  output logic                        player_dead,
  output logic                        win_stage,
  output logic                        busy
`ifdef HIGH_SCORE_EN
  , output logic [4*DIGITS-1:0]       high_bcd
`endif
);

  localparam int SW = 4*DIGITS;
  localparam int KW = $clog2(MONSTERS_PER_STAGE + 1);
  localparam int IW = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [KW-1:0] KILL_MAX = KW'(MONSTERS_PER_STAGE);
  localparam logic [IW-1:0] INV_LOAD = IW'(INVULN_FRAMES);

  score_state_t     state, state_nxt;
  logic [7:0]       pending, pending_nxt;
  logic [8:0]       pts, pend_sum;
  logic             kill_seen, hurt_seen;
  logic             kill_commit, hurt_commit, hurt_take;
  logic [KW-1:0]    kill_cnt, kill_base;
  logic [IW-1:0]    invuln;
  logic             do_inc, all_nine;
  logic [SW-1:0]    score_inc;
  logic [SW-1:0]    disp;
  logic [SEG_W-1:0] seg_w [DIGITS];

  assign kill_commit = startOfFrame & kill_seen;
  assign hurt_commit = startOfFrame & hurt_seen;
  assign hurt_take   = hurt_commit && (invuln == '0) && !player_dead;
  assign pts         = 9'(KILL_POINTS) * (9'(stage_num) + 9'd1);
  assign kill_base   = stage_clear ? '0 : kill_cnt;
  assign busy        = (state == ADD);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_inc    = 1'b0;
    case (state)
      IDLE: if (pending != 8'd0) state_nxt = ADD;
      ADD: begin
        if (pending == 8'd0) state_nxt = IDLE;
        else                 do_inc    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (new_game) state_nxt = IDLE;
    // do_inc implies pending != 0, so the decrement cannot wrap
    pend_sum    = {1'b0, pending} - {8'd0, do_inc} + (kill_commit ? pts : 9'd0);
    pending_nxt = pend_sum[8] ? 8'hFF : pend_sum[7:0];
  end

  always_comb begin
    score_inc = score_bcd;
    all_nine  = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (all_nine) begin
        if (score_bcd[4*d +: 4] == 4'd9) begin
          score_inc[4*d +: 4] = 4'd0;
        end else begin
          score_inc[4*d +: 4] = score_bcd[4*d +: 4] + 4'd1;
          all_nine            = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      pending     <= 8'd0;
      score_bcd   <= '0;
      kill_seen   <= 1'b0;
      hurt_seen   <= 1'b0;
      kill_cnt    <= '0;
      win_stage   <= 1'b0;
      lives       <= 3'(START_LIVES);
      player_dead <= 1'b0;
      invuln      <= '0;
    end else begin
      pending <= pending_nxt;
      if (do_inc && !all_nine) score_bcd <= score_inc;

      // a hit on the commit cycle itself seeds the next frame's latch
      if (!enable) begin
        kill_seen <= 1'b0;
        hurt_seen <= 1'b0;
      end else if (startOfFrame) begin
        kill_seen <= monster_hit;
        hurt_seen <= player_hit;
      end else begin
        kill_seen <= kill_seen | monster_hit;
        hurt_seen <= hurt_seen | player_hit;
      end

      win_stage <= 1'b0;
      if (kill_commit && (kill_base != KILL_MAX)) begin
        kill_cnt  <= kill_base + KW'(1);
        win_stage <= ((kill_base + KW'(1)) == KILL_MAX);
      end else begin
        kill_cnt  <= kill_base;
      end

      if (hurt_take) begin
        lives  <= lives - 3'd1;
        invuln <= INV_LOAD;
        if (lives == 3'd1) player_dead <= 1'b1;
      end else if (startOfFrame && (invuln != '0)) begin
        invuln <= invuln - IW'(1);
      end
    end
  end

`ifdef HIGH_SCORE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      high_bcd <= '0;
    end else if ((state == ADD) && (state_nxt == IDLE) && (score_bcd > high_bcd)) begin
      high_bcd <= score_bcd;
    end
  end

  assign disp = player_dead ? high_bcd : score_bcd;
`else
  assign disp = score_bcd;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_to_7seg u_seg (
      .digit (disp[4*g +: 4]),
      .seg   (seg_w[g])
    );
  end

  always_ff @(posedge clk) begin
    for (int d = 0; d < DIGITS; d++) begin
      if (rst) hex_segments[d*HEX_WIDTH +: HEX_WIDTH] <= HEX_WIDTH'(SEG_TABLE[0]);
      else     hex_segments[d*HEX_WIDTH +: HEX_WIDTH] <= HEX_WIDTH'(seg_w[d]);
    end
  end

endmodule

// File: tb/tb_score_unit.sv
// Directed + randomized bench for score_unit against a frame-level model of
// score, lives, invulnerability and stage kill count.
module tb_score_unit;

  logic        clk = 1'b0;
  logic        rst, startOfFrame, enable, new_game, stage_clear;
  logic [2:0]  stage_num;
  logic        monster_hit, player_hit;
  logic [15:0] score_bcd;
  logic [27:0] hex_segments;
  logic [2:0]  lives;
  logic        player_dead, win_stage, busy;
`ifdef HIGH_SCORE_EN
  logic [15:0] high_bcd;
`endif

  score_unit dut (
    .clk          (clk),
    .rst          (rst),
    .startOfFrame (startOfFrame),
    .enable       (enable),
    .new_game     (new_game),
    .stage_clear  (stage_clear),
    .stage_num    (stage_num),
    .monster_hit  (monster_hit),
    .player_hit   (player_hit),
    .score_bcd    (score_bcd),
    .hex_segments (hex_segments),
    .lives        (lives),
    .player_dead  (player_dead),
    .win_stage    (win_stage),
    .busy         (busy)
`ifdef HIGH_SCORE_EN
    , .high_bcd   (high_bcd)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // frame-level reference state
  int m_score, m_lives, m_inv, m_kills, m_high, stage;
  bit m_dead, exp_win;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [27:0] hex_of(input int v);
    logic [27:0] r;
    int x;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[7*d +: 7] = seg_pat(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_score = 0; m_lives = 3; m_inv = 0; m_kills = 0; m_dead = 0;
  endtask

  task automatic model_commit(input bit k, input bit h);
    exp_win = 0;
    if (k) begin
      m_score += 10 * (stage + 1);
      if (m_score > 9999) m_score = 9999;
      if (m_kills < 16) begin
        m_kills++;
        exp_win = (m_kills == 16);
      end
    end
    if (h && m_inv == 0 && !m_dead) begin
      m_lives--;
      m_inv = 60;
      if (m_lives == 0) m_dead = 1;
    end else if (m_inv > 0) begin
      m_inv--;
    end
  endtask

  task automatic frame(input int len, input bit k, input bit h);
    for (int i = 0; i < len; i++) begin
      monster_hit = k;
      player_hit  = h;
      step();
    end
    monster_hit  = 0;
    player_hit   = 0;
    startOfFrame = 1;
    step();
    startOfFrame = 0;
    model_commit(k && enable && len > 0, h && enable && len > 0);
    check("win_stage", win_stage, exp_win);
  endtask

  task automatic drain();
    int n;
    n = 0;
    step();
    while (busy === 1'b1 && n < 600) begin
      step();
      n++;
    end
    check("drain_timeout", busy, 1'b0);
    if (m_score > m_high) m_high = m_score;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_score"}, score_bcd, to_bcd(m_score));
    check({tag, "_lives"}, lives, 3'(m_lives));
    check({tag, "_dead"}, player_dead, m_dead);
  endtask

  task automatic pulse_new_game();
    new_game = 1;
    step();
    new_game = 0;
    model_reset();
  endtask

  task automatic set_stage(input int s);
    stage     = s;
    stage_num = 3'(s);
  endtask

  initial begin
    rst = 1; startOfFrame = 0; enable = 1; new_game = 0; stage_clear = 0;
    monster_hit = 0; player_hit = 0;
    set_stage(0);
    model_reset();
    m_high = 0;
    step();
    step();
    rst = 0;
    check("rst_score", score_bcd, 16'h0000);
    check("rst_lives", lives, 3'd3);
    check("rst_dead", player_dead, 1'b0);
    check("rst_win", win_stage, 1'b0);
    check("rst_busy", busy, 1'b0);
    step();
    check("rst_hex", hex_segments, hex_of(0));

    // one kill, hit held for 20 cycles in the frame
    frame(20, 1, 0);
    drain();
    check("kill_s0", score_bcd, 16'h0010);
    check_state("kill_s0");

    // stage 2: two kills on back-to-back frames while the adder is busy
    pulse_new_game();
    set_stage(2);
    frame(4, 1, 0);
    check("busy_after_commit", busy, 1'b0);
    frame(4, 1, 0);
    check("busy_during_add", busy, 1'b1);
    drain();
    check("kill_s2_x2", score_bcd, 16'h0060);

    // hit only on the startOfFrame cycle belongs to the next frame
    monster_hit = 1; startOfFrame = 1;
    step();
    monster_hit = 0; startOfFrame = 0;
    model_commit(0, 0);
    check("sof_hit_win", win_stage, exp_win);
    drain();
    check("sof_hit_not_yet", score_bcd, to_bcd(m_score));
    frame(3, 0, 0);
    model_commit(1, 0);
    drain();
    check("sof_hit_next", score_bcd, 16'h0090);

    // stage kill count and win_stage
    pulse_new_game();
    set_stage(0);
    for (int f = 0; f < 18; f++) frame(11, 1, 0);
    stage_clear = 1;
    step();
    stage_clear = 0;
    m_kills = 0;
    for (int f = 0; f < 16; f++) frame(11, 1, 0);
    drain();
    check_state("kills");

    // invulnerability window and death
    pulse_new_game();
    frame(2, 0, 1);
    check("invuln_first", lives, 3'd2);
    for (int f = 2; f <= 61; f++) frame(2, 0, 1);
    check("invuln_held", lives, 3'd2);
    frame(2, 0, 1);
    check("invuln_after", lives, 3'd1);
    for (int f = 0; f < 60; f++) frame(2, 0, 0);
    frame(2, 0, 1);
    check("dead_lives", lives, 3'd0);
    check("dead_flag", player_dead, 1'b1);
    for (int f = 0; f < 3; f++) frame(2, 0, 1);
    check_state("dead_held");
    drain();
    pulse_new_game();
    check_state("new_game_clear");

    // saturation at 9999
    set_stage(0);
    for (int f = 0; f < 999; f++) frame(11, 1, 0);
    drain();
    check("preload", score_bcd, 16'h9990);
    frame(11, 1, 0);
    drain();
    check("sat_9999", score_bcd, 16'h9999);
    frame(11, 1, 0);
    drain();
    check("sat_hold", score_bcd, 16'h9999);
    check("sat_hex", hex_segments, hex_of(9999));
    pulse_new_game();
    check_state("sat_new_game");
    step();
    check("new_game_hex", hex_segments, hex_of(0));
`ifdef HIGH_SCORE_EN
    check("high_survives", high_bcd, to_bcd(m_high));
`endif

    // reset in the middle of an ADD run
    set_stage(7);
    frame(3, 1, 1);
    step();
    step();
    check("mid_add_busy", busy, 1'b1);
    rst = 1;
    step();
    rst = 0;
    model_reset();
    m_high = 0;
    check("rst_add_score", score_bcd, 16'h0000);
    check("rst_add_busy", busy, 1'b0);
    check("rst_add_lives", lives, 3'd3);
    check("rst_add_win", win_stage, 1'b0);
    check("rst_add_dead", player_dead, 1'b0);
    step();
    check("rst_add_busy2", busy, 1'b0);

    // randomized frames
    for (int f = 0; f < 60; f++) begin
      set_stage($urandom_range(0, 7));
      enable = (m_inv == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      frame($urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();
      check_state("rand");
    end
    enable = 1;
`ifdef HIGH_SCORE_EN
    check("high_rand", high_bcd, to_bcd(m_high));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
